// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle stores, fixed-latency loads with a busy
// stall while a load is in flight. Words use [0:DATA_W-1] ordering (bit 0 = MSB).
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memEn,
    input  logic              memWrEn,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [0:DATA_W-1] dataIn,
    output logic              memBusy,
    output logic [0:DATA_W-1] dataOut,
    output logic              dataValid,
    output logic              memWrAck
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        count_reg;
    logic              oor_reg;
    logic [0:DATA_W-1] rd_word_reg;
    logic [0:DATA_W-1] ret_word;
    logic [0:DATA_W-1] mem [DEPTH];

    logic              accept;
    logic              load_accept;
    logic              store_accept;
    logic              in_range;
    logic              last_beat;
    logic              fire;
    logic [IDX_W-1:0]  idx;

    assign idx          = memAddr[IDX_W-1:0];
    assign in_range     = ({1'b0, memAddr} < (ADDR_W+1)'(DEPTH));
    assign accept       = memEn && !memBusy && !reset;
    assign load_accept  = accept && !memWrEn;
    assign store_accept = accept && memWrEn;
    // The counter is preloaded with RD_LAT-1, so its final busy cycle is when it reads 1.
    assign last_beat    = (state_reg == RD_WAIT) && (count_reg == 4'd1);
    assign fire         = (RD_LAT == 1) ? load_accept : last_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_accept && RD_LAT > 1) state_next = RD_WAIT;
            RD_WAIT: if (count_reg == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        memBusy = (state_reg == RD_WAIT);
    end

    // Array write port and registered read capture; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_accept && in_range) begin
            mem[idx] <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (load_accept) begin
            rd_word_reg <= mem[idx];
        end
    end

    always_comb begin
        ret_word = '0;
        if (RD_LAT == 1) begin
            if (in_range) ret_word = mem[idx];
        end else if (!oor_reg) begin
            ret_word = rd_word_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 4'd0;
            oor_reg   <= 1'b0;
            dataValid <= 1'b0;
            memWrAck  <= 1'b0;
            dataOut   <= '0;
        end else begin
            memWrAck  <= store_accept;
            dataValid <= 1'b0;
            if (load_accept) begin
                count_reg <= 4'(RD_LAT - 1);
                oor_reg   <= !in_range;
            end else if (state_reg == RD_WAIT) begin
                count_reg <= count_reg - 4'd1;
            end
            if (fire) begin
                dataValid <= 1'b1;
                dataOut   <= ret_word;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build plus RD_LAT=4 and DEPTH=128 builds
// driven from shared request inputs.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memEn = 1'b0;
    logic        memWrEn = 1'b0;
    logic [7:0]  memAddr = '0;
    logic [0:63] dataIn = '0;

    logic        busy0, dv0, ack0;
    logic [0:63] dout0;
    logic        busy4, dv4, ack4;
    logic [0:63] dout4;
    logic        busy128, dv128, ack128;
    logic [0:63] dout128;

    int run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(256), .RD_LAT(2)) dut0 (
        .clk(clk), .reset(reset), .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr),
        .dataIn(dataIn), .memBusy(busy0), .dataOut(dout0), .dataValid(dv0), .memWrAck(ack0)
    );
    dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(256), .RD_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr),
        .dataIn(dataIn), .memBusy(busy4), .dataOut(dout4), .dataValid(dv4), .memWrAck(ack4)
    );
    dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(128), .RD_LAT(2)) dut128 (
        .clk(clk), .reset(reset), .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr),
        .dataIn(dataIn), .memBusy(busy128), .dataOut(dout128), .dataValid(dv128), .memWrAck(ack128)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input int addr, input longint unsigned data);
        memEn   = 1'b1;
        memWrEn = wr;
        memAddr = 8'(addr);
        dataIn  = data;
    endtask

    task automatic idle();
        memEn   = 1'b0;
        memWrEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (3) step();
        @(negedge clk);
        run++; if ({busy0, dv0, ack0} !== 3'b000) begin
            $display("FAIL reset_flags0 got=%b exp=000", {busy0, dv0, ack0}); failed++; end
        run++; if (dout0 !== 64'd0) begin
            $display("FAIL reset_dout0 got=%0h exp=0", dout0); failed++; end
        run++; if ({busy4, dv4, ack4, busy128, dv128, ack128} !== 6'b0) begin
            $display("FAIL reset_flags_other got=%b exp=000000",
                     {busy4, dv4, ack4, busy128, dv128, ack128}); failed++; end
        reset = 1'b0;
        step();
        $display("[TB] test_reset done");
    endtask

    task automatic test_store_load();
        req(1'b1, 187, 45);
        step();
        @(negedge clk);
        run++; if (ack0 !== 1'b1) begin $display("FAIL t1_ack got=%b exp=1", ack0); failed++; end
        req(1'b0, 187, 0);
        step();
        idle();
        @(negedge clk);
        run++; if ({ack0, busy0, dv0} !== 3'b010) begin
            $display("FAIL t1_busy_cycle ack/busy/dv got=%b exp=010", {ack0, busy0, dv0}); failed++; end
        step();
        @(negedge clk);
        run++; if ({busy0, dv0} !== 2'b01 || dout0 !== 64'd45) begin
            $display("FAIL t1_return busy/dv got=%b exp=01 dout got=%0d exp=45", {busy0, dv0}, dout0); failed++; end
        step();
        @(negedge clk);
        run++; if (dv0 !== 1'b0 || dout0 !== 64'd45) begin
            $display("FAIL t1_hold dv got=%b exp=0 dout got=%0d exp=45", dv0, dout0); failed++; end
        $display("[TB] store/load 187: dout=%0d", dout0);
    endtask

    task automatic test_busy_drop();
        req(1'b0, 187, 0);
        step();
        req(1'b1, 187, 99);
        @(negedge clk);
        run++; if (busy0 !== 1'b1) begin $display("FAIL t2_busy got=%b exp=1", busy0); failed++; end
        step();
        idle();
        @(negedge clk);
        run++; if (dv0 !== 1'b1 || ack0 !== 1'b0 || dout0 !== 64'd45) begin
            $display("FAIL t2_return dv got=%b exp=1 ack got=%b exp=0 dout got=%0d exp=45", dv0, ack0, dout0); failed++; end
        step();
        req(1'b0, 187, 0);
        step();
        idle();
        step();
        @(negedge clk);
        run++; if (dv0 !== 1'b1 || dout0 !== 64'd45) begin
            $display("FAIL t2_reload dv got=%b exp=1 dout got=%0d exp=45", dv0, dout0); failed++; end
        $display("[TB] dropped store during busy: reload dout=%0d", dout0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 10 + i, 64'(i + 1));
            step();
            @(negedge clk);
            run++; if (ack0 !== 1'b1) begin $display("FAIL t3_ack%0d got=%b exp=1", i, ack0); failed++; end
        end
        for (int i = 0; i < 3; i++) begin
            req(1'b0, 10 + i, 0);
            step();
            idle();
            step();
            @(negedge clk);
            run++; if (dv0 !== 1'b1 || dout0 !== 64'(i + 1)) begin
                $display("FAIL t3_load%0d dv got=%b exp=1 dout got=%0d exp=%0d", i, dv0, dout0, i + 1); failed++; end
            $display("[TB] load %0d -> %0d", 10 + i, dout0);
        end
        step();
    endtask

    task automatic test_reset_abort();
        req(1'b0, 10, 0);
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        run++; if (busy0 !== 1'b1) begin $display("FAIL t4_busy_pre got=%b exp=1", busy0); failed++; end
        step();
        reset = 1'b0;
        @(negedge clk);
        run++; if ({busy0, dv0} !== 2'b00 || dout0 !== 64'd0) begin
            $display("FAIL t4_abort busy/dv got=%b exp=00 dout got=%0d exp=0", {busy0, dv0}, dout0); failed++; end
        step();
        @(negedge clk);
        run++; if (dv0 !== 1'b0) begin $display("FAIL t4_no_pulse got=%b exp=0", dv0); failed++; end
        // A store presented together with reset must be ignored.
        reset = 1'b1;
        req(1'b1, 12, 77);
        step();
        reset = 1'b0;
        req(1'b0, 10, 0);
        @(negedge clk);
        run++; if (ack0 !== 1'b0) begin $display("FAIL t4_reset_store_ack got=%b exp=0", ack0); failed++; end
        step();
        idle();
        step();
        @(negedge clk);
        run++; if (dv0 !== 1'b1 || dout0 !== 64'd1) begin
            $display("FAIL t4_reload10 dv got=%b exp=1 dout got=%0d exp=1", dv0, dout0); failed++; end
        req(1'b0, 12, 0);
        step();
        idle();
        step();
        @(negedge clk);
        run++; if (dout0 !== 64'd3) begin
            $display("FAIL t4_reload12 got=%0d exp=3", dout0); failed++; end
        $display("[TB] reset abort: reload 10=1, 12=%0d", dout0);
        step();
    endtask

    task automatic test_latency4();
        int busy_cnt;
        req(1'b1, 11, 2);
        step();
        idle();
        step();
        req(1'b0, 11, 0);
        step();
        idle();
        busy_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (busy4 === 1'b1) busy_cnt++;
            if (k < 4) begin
                run++; if (dv4 !== 1'b0) begin $display("FAIL t5_early_valid c+%0d got=%b exp=0", k, dv4); failed++; end
            end else begin
                run++; if (dv4 !== 1'b1 || busy4 !== 1'b0 || dout4 !== 64'd2) begin
                    $display("FAIL t5_return dv got=%b exp=1 busy got=%b exp=0 dout got=%0d exp=2", dv4, busy4, dout4); failed++; end
            end
            step();
        end
        run++; if (busy_cnt != 3) begin $display("FAIL t5_busy_cycles got=%0d exp=3", busy_cnt); failed++; end
        @(negedge clk);
        run++; if (dv4 !== 1'b0) begin $display("FAIL t5_pulse_width got=%b exp=0", dv4); failed++; end
        $display("[TB] RD_LAT=4 load 11: busy cycles=%0d dout=%0d", busy_cnt, dout4);
    endtask

    task automatic test_out_of_range();
        req(1'b1, 72, 64'h55);
        step();
        req(1'b1, 200, 7);
        step();
        @(negedge clk);
        run++; if (ack128 !== 1'b1) begin $display("FAIL t6_oor_ack got=%b exp=1", ack128); failed++; end
        req(1'b0, 72, 0);
        step();
        idle();
        step();
        @(negedge clk);
        run++; if (dv128 !== 1'b1 || dout128 !== 64'h55) begin
            $display("FAIL t6_mem72 dv got=%b exp=1 dout got=%0h exp=55", dv128, dout128); failed++; end
        req(1'b0, 200, 0);
        step();
        idle();
        step();
        @(negedge clk);
        run++; if (dv128 !== 1'b1 || dout128 !== 64'd0) begin
            $display("FAIL t6_oor_load dv got=%b exp=1 dout got=%0h exp=0", dv128, dout128); failed++; end
        $display("[TB] DEPTH=128 load 200 -> %0h", dout128);
        step();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_busy_drop();
        test_back_to_back();
        test_reset_abort();
        test_reset();
        test_latency4();
        test_reset();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", run, failed);
        $finish;
    end
endmodule
